// File: rtl/alice4_avalon_pkg.sv
// Shared Avalon/SDRAM definitions for the f2h_sdram read-port stand-in: widths,
// the command record and the deterministic beat pattern.
package alice4_avalon_pkg;

  localparam int unsigned SDRAM_ADDR_BITS  = 29;
  localparam int unsigned SDRAM_DATA_BITS  = 64;
  localparam int unsigned SDRAM_BURST_BITS = 8;
  localparam logic [SDRAM_DATA_BITS-1:0] ERROR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic [SDRAM_ADDR_BITS-1:0]  addr;
    logic [SDRAM_BURST_BITS-1:0] burst;
  } cmd_t;

  typedef enum logic {IDLE, BURST} beat_state_t;

  function automatic logic [SDRAM_DATA_BITS-1:0] pattern(input logic [SDRAM_ADDR_BITS-1:0] a,
                                                         input logic [31:0] seed);
    logic [31:0] w;
    w = {3'b000, a};
    return {seed ^ w, w};
  endfunction

  // A zero burstcount still returns one beat.
  function automatic logic [SDRAM_BURST_BITS-1:0] burst_len(input logic [SDRAM_BURST_BITS-1:0] b);
    return (b == '0) ? SDRAM_BURST_BITS'(1) : b;
  endfunction

endpackage

// File: rtl/avalon_burst_read_responder_if.sv
// Avalon-MM burst-read bus between a read master and the responder.
interface avalon_burst_read_responder_if;
  import alice4_avalon_pkg::*;

  logic [SDRAM_ADDR_BITS-1:0]  address;
  logic [SDRAM_BURST_BITS-1:0] burstcount;
  logic                        read;
  logic                        waitrequest;
  logic [SDRAM_DATA_BITS-1:0]  readdata;
  logic                        readdatavalid;

  modport master (output address, burstcount, read,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, burstcount, read,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/avalon_burst_read_responder_cmd_fifo.sv
// Synchronous command FIFO (responder_cmd_fifo) with full/empty/level; head is show-ahead.
module responder_cmd_fifo import alice4_avalon_pkg::*; #(
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic             clock_50,
  input  logic             reset_n,
  input  logic             push,
  input  cmd_t             push_cmd,
  input  logic             pop,
  output cmd_t             head,
  output logic             full,
  output logic             empty,
  output logic [FIFO_LOG2:0] level
);
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;

  cmd_t                   mem [DEPTH];
  logic [FIFO_LOG2-1:0]   wr_ptr;
  logic [FIFO_LOG2-1:0]   rd_ptr;
  logic [FIFO_LOG2:0]     count;

  always_ff @(posedge clock_50) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (FIFO_LOG2+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
endmodule

// File: rtl/avalon_burst_read_responder.sv
// Avalon-MM burst-read slave returning pattern data with traffic/error counters.
// Optional random stalls on commands and beats: define AVALON_RESPONDER_STALL_EN.
module avalon_burst_read_responder import alice4_avalon_pkg::*; #(
  parameter int unsigned          ADDR_BITS    = SDRAM_ADDR_BITS,
  parameter int unsigned          BURST_BITS   = SDRAM_BURST_BITS,
  parameter logic [ADDR_BITS-1:0] BASE_WORD    = 29'h0700_0000,
  parameter logic [ADDR_BITS-1:0] WINDOW_WORDS = 29'h0017_7000,
  parameter int unsigned          FIFO_LOG2    = 2,
  parameter logic [31:0]          SEED         = 32'hA11C_E400
) (
  input  logic                          clock_50,
  input  logic                          reset_n,
  avalon_burst_read_responder_if.slave  bus,
  output logic [31:0]                   debug_value0,
  output logic [31:0]                   debug_value1,
  output logic [31:0]                   debug_value2
);

  function automatic logic in_window(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS:0] lo;
    logic [ADDR_BITS:0] hi;
    lo = {1'b0, BASE_WORD};
    hi = {1'b0, BASE_WORD} + {1'b0, WINDOW_WORDS};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  beat_state_t           state, state_nxt;
  logic [ADDR_BITS-1:0]  cur_addr, addr_nxt, beat_addr;
  logic [BURST_BITS-1:0] beats_left, left_nxt;
  logic                  pop, issue, zero_err, oow, push;
  logic                  full, empty, stall_cmd, stall_beat;
  logic [FIFO_LOG2:0]    level;
  cmd_t                  head;
  logic [31:0]           cmd_count, beat_count;
  logic [15:0]           errors;

`ifdef AVALON_RESPONDER_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall_cmd  = (lfsr[1:0] == 2'b00);
  assign stall_beat = (lfsr[3:2] == 2'b00);
`else
  assign stall_cmd  = 1'b0;
  assign stall_beat = 1'b0;
`endif

  // Command accept: full is judged on the registered level, so a same-cycle pop never admits a push.
  assign bus.waitrequest = full | (bus.read & stall_cmd);
  assign push            = bus.read & ~bus.waitrequest;

  responder_cmd_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .push     (push),
    .push_cmd ('{addr: bus.address, burst: bus.burstcount}),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Beat engine: IDLE issues beat 0 straight from the FIFO head to reach the two-cycle latency.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    zero_err  = 1'b0;
    beat_addr = cur_addr;
    addr_nxt  = cur_addr;
    left_nxt  = beats_left;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          issue     = 1'b1;
          zero_err  = (head.burst == '0);
          beat_addr = head.addr;
          addr_nxt  = head.addr + 1'b1;
          left_nxt  = burst_len(head.burst) - 1'b1;
          state_nxt = (left_nxt != '0) ? BURST : IDLE;
        end
      end
      BURST: begin
        if (!stall_beat) begin
          issue    = 1'b1;
          addr_nxt = cur_addr + 1'b1;
          left_nxt = beats_left - 1'b1;
          if (beats_left == BURST_BITS'(1)) begin
            if (!empty) begin
              pop      = 1'b1;
              zero_err = (head.burst == '0);
              addr_nxt = head.addr;
              left_nxt = burst_len(head.burst);
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign oow = issue & ~in_window(beat_addr);

  // Registered beat output and debug counters.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cur_addr          <= '0;
      beats_left        <= '0;
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
      cmd_count         <= '0;
      beat_count        <= '0;
      errors            <= '0;
    end else begin
      state             <= state_nxt;
      cur_addr          <= addr_nxt;
      beats_left        <= left_nxt;
      bus.readdatavalid <= issue;
      if (issue) begin
        bus.readdata <= in_window(beat_addr) ? pattern(beat_addr, SEED) : ERROR_PATTERN;
        beat_count   <= sat_inc32(beat_count);
      end
      if (push) cmd_count <= sat_inc32(cmd_count);
      errors <= sat_add16(errors, {1'b0, oow} + {1'b0, zero_err});
    end
  end

  assign debug_value0 = cmd_count;
  assign debug_value1 = beat_count;
  assign debug_value2 = {errors, 8'(level), 7'd0, (state == BURST) | ~empty};

endmodule
